// File: rtl/udma_smi_pkg.sv
// Shared types and constants for the Clause 22 SMI (MDIO) responder.
// Holds the frame-decoder states, opcode/turnaround codes and the preamble qualification helper.
package udma_smi_pkg;

    typedef enum logic [2:0] {
        HUNT,
        SOF,
        OP,
        PHYAD,
        REGAD,
        TA,
        DATA
    } smi_state_e;

    localparam logic [1:0] SMI_OP_WR        = 2'b01;
    localparam logic [1:0] SMI_OP_RD        = 2'b10;
    localparam logic [1:0] SMI_TA_WR        = 2'b10;
    localparam int         SMI_PREAMBLE_MAX = 32;
    localparam int         SMI_ADDR_W       = 5;
    localparam int         SMI_DATA_W       = 16;

    // The 5-bit counter saturates at 31, so a 32nd consecutive one is remembered by 'full'.
    function automatic logic smi_preamble_ok(input logic [4:0] cnt,
                                             input logic       full,
                                             input logic [5:0] len);
        return full | ({1'b0, cnt} >= len);
    endfunction

endpackage

// File: rtl/udma_smi_edge_sync.sv
// Brings MDC and MDIO into the clk_i domain and flags each MDC rising edge.
// Both lines use the same depth so the sampled MDIO bit lines up with its MDC rise.
module udma_smi_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic i_mdc,
    input  logic i_mdi,
    output logic o_mdc_rise,
    output logic o_mdi
);

    logic [SYNC_STAGES-1:0] r_mdc_sync;
    logic [SYNC_STAGES-1:0] r_mdi_sync;
    logic                   r_mdc_d;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_mdc_sync <= '0;
            r_mdi_sync <= '0;
            r_mdc_d    <= 1'b0;
        end else begin
            r_mdc_sync <= {r_mdc_sync[SYNC_STAGES-2:0], i_mdc};
            r_mdi_sync <= {r_mdi_sync[SYNC_STAGES-2:0], i_mdi};
            r_mdc_d    <= r_mdc_sync[SYNC_STAGES-1];
        end
    end

    assign o_mdc_rise = r_mdc_sync[SYNC_STAGES-1] & ~r_mdc_d;
    assign o_mdi      = r_mdi_sync[SYNC_STAGES-1];

endmodule

// File: rtl/udma_smi_responder.sv
// PHY-side Clause 22 management frame responder: decodes frames on oversampled MDC rises,
// serves reads from an external register port and issues write strobes to it.
module udma_smi_responder
    import udma_smi_pkg::*;
#(
    parameter int PREAMBLE_LEN = 32,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  mdc_i,
    input  logic                  mdi_i,
    output logic                  mdo_o,
    output logic                  md_oen_o,
    input  logic [SMI_ADDR_W-1:0] phy_addr_i,
    output logic [SMI_ADDR_W-1:0] reg_addr_o,
    output logic                  rd_req_o,
    input  logic [SMI_DATA_W-1:0] rd_data_i,
    output logic                  wr_en_o,
    output logic [SMI_DATA_W-1:0] wr_data_o,
    output logic                  busy_o,
    output logic                  err_o
);

    localparam int         LP_PRE_CLAMP = (PREAMBLE_LEN > SMI_PREAMBLE_MAX) ? SMI_PREAMBLE_MAX
                                                                            : PREAMBLE_LEN;
    localparam logic [5:0] LP_PRE_LEN   = LP_PRE_CLAMP[5:0];

    logic                  w_rise;
    logic                  w_mdi;
    logic [SMI_ADDR_W-1:0] w_field;

    smi_state_e            r_state, w_state_nxt;
    logic [4:0]            r_bit_cnt, w_bit_cnt_nxt;
    logic [4:0]            r_pre_cnt, w_pre_cnt_nxt;
    logic                  r_pre_full, w_pre_full_nxt;
    logic                  r_is_read, w_is_read_nxt;
    logic                  r_bit_hold, w_bit_hold_nxt;
    logic [3:0]            r_addr_sh, w_addr_sh_nxt;
    logic [SMI_DATA_W-1:0] r_shreg, w_shreg_nxt;
    logic                  r_rd_cap, w_rd_cap_nxt;
    logic                  r_mdo, w_mdo_nxt;
    logic                  r_oen, w_oen_nxt;
    logic [SMI_ADDR_W-1:0] r_reg_addr, w_reg_addr_nxt;
    logic                  r_rd_req, w_rd_req_nxt;
    logic                  r_wr_en, w_wr_en_nxt;
    logic [SMI_DATA_W-1:0] r_wr_data, w_wr_data_nxt;
    logic                  r_busy, w_busy_nxt;
    logic                  r_err, w_err_nxt;

    udma_smi_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .i_mdc      (mdc_i),
        .i_mdi      (mdi_i),
        .o_mdc_rise (w_rise),
        .o_mdi      (w_mdi)
    );

    // Address fields arrive MSB first; the fifth bit completes the word straight from the line.
    assign w_field = {r_addr_sh, w_mdi};

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_pre_cnt_nxt  = r_pre_cnt;
        w_pre_full_nxt = r_pre_full;
        w_is_read_nxt  = r_is_read;
        w_bit_hold_nxt = r_bit_hold;
        w_addr_sh_nxt  = r_addr_sh;
        w_shreg_nxt    = r_shreg;
        w_rd_cap_nxt   = r_rd_req;
        w_mdo_nxt      = r_mdo;
        w_oen_nxt      = r_oen;
        w_reg_addr_nxt = r_reg_addr;
        w_rd_req_nxt   = 1'b0;
        w_wr_en_nxt    = 1'b0;
        w_wr_data_nxt  = r_wr_data;
        w_err_nxt      = 1'b0;

        // Read data lands one cycle after the request pulse, long before the next MDC rise.
        if (r_rd_cap) begin
            w_shreg_nxt = rd_data_i;
        end

        if (w_rise) begin
            case (r_state)
                HUNT: begin
                    if (w_mdi) begin
                        if (r_pre_cnt == 5'd31) begin
                            w_pre_full_nxt = 1'b1;
                        end else begin
                            w_pre_cnt_nxt = r_pre_cnt + 5'd1;
                        end
                    end else begin
                        w_pre_cnt_nxt  = 5'd0;
                        w_pre_full_nxt = 1'b0;
                        if (smi_preamble_ok(r_pre_cnt, r_pre_full, LP_PRE_LEN)) begin
                            w_state_nxt = SOF;
                        end
                    end
                end

                SOF: begin
                    w_bit_cnt_nxt = 5'd0;
                    if (w_mdi) begin
                        w_state_nxt = OP;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = HUNT;
                    end
                end

                OP: begin
                    if (r_bit_cnt == 5'd0) begin
                        w_bit_hold_nxt = w_mdi;
                        w_bit_cnt_nxt  = 5'd1;
                    end else begin
                        w_bit_cnt_nxt = 5'd0;
                        if (({r_bit_hold, w_mdi} == SMI_OP_WR) || ({r_bit_hold, w_mdi} == SMI_OP_RD)) begin
                            w_is_read_nxt = ({r_bit_hold, w_mdi} == SMI_OP_RD);
                            w_state_nxt   = PHYAD;
                        end else begin
                            w_err_nxt   = 1'b1;
                            w_state_nxt = HUNT;
                        end
                    end
                end

                PHYAD: begin
                    if (r_bit_cnt == 5'd4) begin
                        w_bit_cnt_nxt = 5'd0;
                        // A frame for another PHY is dropped without any visible reaction.
                        w_state_nxt   = (w_field == phy_addr_i) ? REGAD : HUNT;
                    end else begin
                        w_addr_sh_nxt = w_field[3:0];
                        w_bit_cnt_nxt = r_bit_cnt + 5'd1;
                    end
                end

                REGAD: begin
                    if (r_bit_cnt == 5'd4) begin
                        w_bit_cnt_nxt  = 5'd0;
                        w_reg_addr_nxt = w_field;
                        w_rd_req_nxt   = r_is_read;
                        w_state_nxt    = TA;
                    end else begin
                        w_addr_sh_nxt = w_field[3:0];
                        w_bit_cnt_nxt = r_bit_cnt + 5'd1;
                    end
                end

                TA: begin
                    if (r_bit_cnt == 5'd0) begin
                        w_bit_hold_nxt = w_mdi;
                        w_bit_cnt_nxt  = 5'd1;
                        if (r_is_read) begin
                            w_oen_nxt = 1'b0;
                        end
                    end else begin
                        w_bit_cnt_nxt = 5'd0;
                        if (r_is_read) begin
                            w_oen_nxt   = 1'b1;
                            w_mdo_nxt   = 1'b0;
                            w_state_nxt = DATA;
                        end else if ({r_bit_hold, w_mdi} == SMI_TA_WR) begin
                            w_state_nxt = DATA;
                        end else begin
                            w_err_nxt   = 1'b1;
                            w_state_nxt = HUNT;
                        end
                    end
                end

                DATA: begin
                    if (r_is_read) begin
                        // Sixteen rises drive D15..D0; the seventeenth releases the line.
                        if (r_bit_cnt == 5'd16) begin
                            w_oen_nxt     = 1'b0;
                            w_mdo_nxt     = 1'b0;
                            w_bit_cnt_nxt = 5'd0;
                            w_state_nxt   = HUNT;
                        end else begin
                            w_mdo_nxt     = r_shreg[SMI_DATA_W-1];
                            w_shreg_nxt   = {r_shreg[SMI_DATA_W-2:0], 1'b0};
                            w_bit_cnt_nxt = r_bit_cnt + 5'd1;
                        end
                    end else begin
                        w_shreg_nxt = {r_shreg[SMI_DATA_W-2:0], w_mdi};
                        if (r_bit_cnt == 5'd15) begin
                            w_wr_data_nxt = {r_shreg[SMI_DATA_W-2:0], w_mdi};
                            w_wr_en_nxt   = 1'b1;
                            w_bit_cnt_nxt = 5'd0;
                            w_state_nxt   = HUNT;
                        end else begin
                            w_bit_cnt_nxt = r_bit_cnt + 5'd1;
                        end
                    end
                end

                default: begin
                    w_state_nxt = HUNT;
                end
            endcase
        end

        w_busy_nxt = (w_state_nxt != HUNT);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_bit_cnt  <= '0;
            r_pre_cnt  <= '0;
            r_pre_full <= 1'b0;
            r_is_read  <= 1'b0;
            r_bit_hold <= 1'b0;
            r_addr_sh  <= '0;
            r_shreg    <= '0;
            r_rd_cap   <= 1'b0;
            r_mdo      <= 1'b0;
            r_oen      <= 1'b0;
            r_reg_addr <= '0;
            r_rd_req   <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_data  <= '0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_pre_cnt  <= w_pre_cnt_nxt;
            r_pre_full <= w_pre_full_nxt;
            r_is_read  <= w_is_read_nxt;
            r_bit_hold <= w_bit_hold_nxt;
            r_addr_sh  <= w_addr_sh_nxt;
            r_shreg    <= w_shreg_nxt;
            r_rd_cap   <= w_rd_cap_nxt;
            r_mdo      <= w_mdo_nxt;
            r_oen      <= w_oen_nxt;
            r_reg_addr <= w_reg_addr_nxt;
            r_rd_req   <= w_rd_req_nxt;
            r_wr_en    <= w_wr_en_nxt;
            r_wr_data  <= w_wr_data_nxt;
            r_busy     <= w_busy_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign mdo_o      = r_mdo;
    assign md_oen_o   = r_oen;
    assign reg_addr_o = r_reg_addr;
    assign rd_req_o   = r_rd_req;
    assign wr_en_o    = r_wr_en;
    assign wr_data_o  = r_wr_data;
    assign busy_o     = r_busy;
    assign err_o      = r_err;

endmodule

// File: tb/tb_udma_smi_responder.sv
// Directed bench for udma_smi_responder: acts as the SMI master with a pulled-up MDIO line
// and a small register-file model behind the read port.
module tb_udma_smi_responder;

    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        rstn;
    logic        mdc;
    logic        mOe;
    logic        mBit;
    logic        mdLine;
    logic        mdo;
    logic        mdOen;
    logic [4:0]  phyAddr;
    logic [4:0]  regAddr;
    logic        rdReq;
    logic [15:0] rdData = 16'hDEAD;
    logic        wrEn;
    logic [15:0] wrData;
    logic        busy;
    logic        err;

    int nCompared   = 0;
    int nMismatched = 0;
    int rdCnt  = 0;
    int wrCnt  = 0;
    int errCnt = 0;
    int oenCnt = 0;
    logic reqD = 1'b0;

    always #5 clk = ~clk;

    assign mdLine = mdOen ? mdo : (mOe ? mBit : 1'b1);

    udma_smi_responder #(
        .PREAMBLE_LEN (32),
        .SYNC_STAGES  (2)
    ) dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .mdc_i      (mdc),
        .mdi_i      (mdLine),
        .mdo_o      (mdo),
        .md_oen_o   (mdOen),
        .phy_addr_i (phyAddr),
        .reg_addr_o (regAddr),
        .rd_req_o   (rdReq),
        .rd_data_i  (rdData),
        .wr_en_o    (wrEn),
        .wr_data_o  (wrData),
        .busy_o     (busy),
        .err_o      (err)
    );

    function automatic logic [15:0] regVal(input logic [4:0] a);
        case (a)
            5'h02:   return 16'h1234;
            5'h1F:   return 16'h8001;
            default: return 16'h0BAD;
        endcase
    endfunction

    // Pulse counters plus the register file: data is valid for the two cycles after a request.
    always @(negedge clk) begin
        if (rdReq) rdCnt++;
        if (wrEn) wrCnt++;
        if (err) errCnt++;
        if (mdOen) oenCnt++;
        if (rdReq) rdData = regVal(regAddr);
        else if (!reqD) rdData = 16'hDEAD;
        reqD = rdReq;
    end

    task automatic mdcCycle(input logic drive, input logic val);
        mdc  = 1'b0;
        mOe  = drive;
        mBit = val;
        repeat (HALF) @(negedge clk);
        mdc = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic sendBits(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) mdcCycle(1'b1, bits[i]);
    endtask

    task automatic sendHeader(input int pre, input logic [1:0] op, input logic [4:0] phy,
                              input logic [4:0] regA);
        mdcCycle(1'b1, 1'b0);
        for (int i = 0; i < pre; i++) mdcCycle(1'b1, 1'b1);
        sendBits({18'd0, 2'b01, op, phy, regA}, 14);
    endtask

    task automatic writeFrame(input int pre, input logic [4:0] phy, input logic [4:0] regA,
                              input logic [1:0] ta, input logic [15:0] data);
        sendHeader(pre, 2'b01, phy, regA);
        sendBits({14'd0, ta, data}, 18);
        mdcCycle(1'b1, 1'b1);
    endtask

    task automatic readFrame(input logic [4:0] phy, input logic [4:0] regA,
                             output logic [15:0] rdata, output logic oen1, output logic oen2,
                             output logic mdo2, output logic oenEnd);
        sendHeader(32, 2'b10, phy, regA);
        mdcCycle(1'b0, 1'b0);
        oen1 = mdOen;
        mdcCycle(1'b0, 1'b0);
        oen2 = mdOen;
        mdo2 = mdo;
        rdata = '0;
        for (int i = 0; i < 16; i++) begin
            mdcCycle(1'b0, 1'b0);
            rdata = {rdata[14:0], mdLine};
        end
        mdcCycle(1'b0, 1'b0);
        oenEnd = mdOen;
        mdcCycle(1'b1, 1'b1);
    endtask

    task automatic test_reset;
        rstn = 1'b0; mdc = 1'b0; mOe = 1'b1; mBit = 1'b1; phyAddr = 5'h03;
        repeat (3) @(negedge clk);
        nCompared++;
        if ({mdo, mdOen, rdReq, wrEn, busy, err} !== 6'b0) begin
            nMismatched++;
            $display("[TB] FAIL reset_flags: got %b expected 000000", {mdo, mdOen, rdReq, wrEn, busy, err});
        end
        nCompared++;
        if (regAddr !== 5'h00) begin
            nMismatched++; $display("[TB] FAIL reset_reg_addr: got %h expected 00", regAddr);
        end
        nCompared++;
        if (wrData !== 16'h0000) begin
            nMismatched++; $display("[TB] FAIL reset_wr_data: got %h expected 0000", wrData);
        end
        rstn = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_write;
        int w0, e0, o0;
        w0 = wrCnt; e0 = errCnt; o0 = oenCnt;
        sendHeader(32, 2'b01, 5'h03, 5'h11);
        nCompared++;
        if (busy !== 1'b1) begin
            nMismatched++; $display("[TB] FAIL write_busy_mid: got %b expected 1", busy);
        end
        sendBits({14'd0, 2'b10, 16'hA5C3}, 18);
        mdcCycle(1'b1, 1'b1);
        nCompared++;
        if (wrCnt - w0 !== 1) begin
            nMismatched++; $display("[TB] FAIL write_strobes: got %0d expected 1", wrCnt - w0);
        end
        nCompared++;
        if (regAddr !== 5'h11) begin
            nMismatched++; $display("[TB] FAIL write_reg_addr: got %h expected 11", regAddr);
        end
        nCompared++;
        if (wrData !== 16'hA5C3) begin
            nMismatched++; $display("[TB] FAIL write_data: got %h expected a5c3", wrData);
        end
        nCompared++;
        if (oenCnt - o0 !== 0 || errCnt - e0 !== 0) begin
            nMismatched++;
            $display("[TB] FAIL write_no_drive: got oen %0d err %0d expected 0 0", oenCnt - o0, errCnt - e0);
        end
        nCompared++;
        if (busy !== 1'b0) begin
            nMismatched++; $display("[TB] FAIL write_busy_end: got %b expected 0", busy);
        end
    endtask

    task automatic test_read;
        int r0;
        logic [15:0] rd;
        logic o1, o2, m2, oe;
        r0 = rdCnt;
        readFrame(5'h03, 5'h02, rd, o1, o2, m2, oe);
        nCompared++;
        if (rdCnt - r0 !== 1) begin
            nMismatched++; $display("[TB] FAIL read_requests: got %0d expected 1", rdCnt - r0);
        end
        nCompared++;
        if ({o1, o2, m2} !== 3'b010) begin
            nMismatched++; $display("[TB] FAIL read_turnaround: got oen/oen/mdo %b expected 010", {o1, o2, m2});
        end
        nCompared++;
        if (rd !== 16'h1234) begin
            nMismatched++; $display("[TB] FAIL read_data: got %h expected 1234", rd);
        end
        nCompared++;
        if (oe !== 1'b0 || busy !== 1'b0) begin
            nMismatched++; $display("[TB] FAIL read_release: got oen %b busy %b expected 0 0", oe, busy);
        end
        nCompared++;
        if (regAddr !== 5'h02) begin
            nMismatched++; $display("[TB] FAIL read_reg_addr: got %h expected 02", regAddr);
        end
    endtask

    task automatic test_phy_mismatch;
        int r0, w0, e0, o0;
        logic [15:0] rd;
        logic o1, o2, m2, oe;
        r0 = rdCnt; w0 = wrCnt; e0 = errCnt; o0 = oenCnt;
        readFrame(5'h07, 5'h09, rd, o1, o2, m2, oe);
        nCompared++;
        if (rdCnt - r0 !== 0 || wrCnt - w0 !== 0 || errCnt - e0 !== 0) begin
            nMismatched++;
            $display("[TB] FAIL mismatch_strobes: got rd %0d wr %0d err %0d expected 0 0 0",
                     rdCnt - r0, wrCnt - w0, errCnt - e0);
        end
        nCompared++;
        if (oenCnt - o0 !== 0 || rd !== 16'hFFFF) begin
            nMismatched++;
            $display("[TB] FAIL mismatch_drive: got oen %0d line %h expected 0 ffff", oenCnt - o0, rd);
        end
        nCompared++;
        if (regAddr !== 5'h02) begin
            nMismatched++; $display("[TB] FAIL mismatch_reg_addr: got %h expected 02", regAddr);
        end
        r0 = rdCnt;
        readFrame(5'h03, 5'h1F, rd, o1, o2, m2, oe);
        nCompared++;
        if (rd !== 16'h8001 || rdCnt - r0 !== 1) begin
            nMismatched++;
            $display("[TB] FAIL mismatch_next_read: got %h req %0d expected 8001 1", rd, rdCnt - r0);
        end
    endtask

    task automatic test_short_preamble;
        int w0, e0;
        w0 = wrCnt; e0 = errCnt;
        writeFrame(31, 5'h03, 5'h04, 2'b10, 16'h1111);
        nCompared++;
        if (wrCnt - w0 !== 0 || errCnt - e0 !== 0 || wrData !== 16'hA5C3) begin
            nMismatched++;
            $display("[TB] FAIL short_preamble: got wr %0d err %0d data %h expected 0 0 a5c3",
                     wrCnt - w0, errCnt - e0, wrData);
        end
        writeFrame(32, 5'h03, 5'h04, 2'b10, 16'h1111);
        nCompared++;
        if (wrCnt - w0 !== 1 || wrData !== 16'h1111 || regAddr !== 5'h04) begin
            nMismatched++;
            $display("[TB] FAIL full_preamble: got wr %0d data %h reg %h expected 1 1111 04",
                     wrCnt - w0, wrData, regAddr);
        end
    endtask

    task automatic test_bad_frames;
        int w0, r0, e0;
        w0 = wrCnt; r0 = rdCnt; e0 = errCnt;
        mdcCycle(1'b1, 1'b0);
        for (int i = 0; i < 32; i++) mdcCycle(1'b1, 1'b1);
        sendBits(32'h0, 2);
        mdcCycle(1'b1, 1'b1);
        nCompared++;
        if (errCnt - e0 !== 1 || busy !== 1'b0) begin
            nMismatched++; $display("[TB] FAIL bad_sof: got err %0d busy %b expected 1 0", errCnt - e0, busy);
        end
        e0 = errCnt;
        sendHeader(32, 2'b11, 5'h03, 5'h01);
        mdcCycle(1'b1, 1'b1);
        nCompared++;
        if (errCnt - e0 !== 1 || busy !== 1'b0) begin
            nMismatched++; $display("[TB] FAIL bad_op_11: got err %0d busy %b expected 1 0", errCnt - e0, busy);
        end
        e0 = errCnt;
        sendHeader(32, 2'b00, 5'h03, 5'h01);
        mdcCycle(1'b1, 1'b1);
        nCompared++;
        if (errCnt - e0 !== 1) begin
            nMismatched++; $display("[TB] FAIL bad_op_00: got err %0d expected 1", errCnt - e0);
        end
        e0 = errCnt;
        writeFrame(32, 5'h03, 5'h08, 2'b11, 16'h00FF);
        nCompared++;
        if (errCnt - e0 !== 1 || wrData !== 16'h1111) begin
            nMismatched++; $display("[TB] FAIL bad_ta: got err %0d data %h expected 1 1111", errCnt - e0, wrData);
        end
        nCompared++;
        if (wrCnt - w0 !== 0 || rdCnt - r0 !== 0) begin
            nMismatched++;
            $display("[TB] FAIL bad_frames_strobes: got wr %0d rd %0d expected 0 0", wrCnt - w0, rdCnt - r0);
        end
    endtask

    task automatic test_reset_mid_read;
        int r0, w0;
        logic [15:0] rd;
        logic o1, o2, m2, oe;
        r0 = rdCnt; w0 = wrCnt;
        sendHeader(32, 2'b10, 5'h03, 5'h02);
        mdcCycle(1'b0, 1'b0);
        mdcCycle(1'b0, 1'b0);
        for (int i = 0; i < 7; i++) mdcCycle(1'b0, 1'b0);
        nCompared++;
        if (mdOen !== 1'b1) begin
            nMismatched++; $display("[TB] FAIL midread_driving: got %b expected 1", mdOen);
        end
        mdc = 1'b0;
        repeat (HALF / 2) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        nCompared++;
        if ({mdOen, busy, mdo} !== 3'b000) begin
            nMismatched++; $display("[TB] FAIL midread_reset: got oen/busy/mdo %b expected 000", {mdOen, busy, mdo});
        end
        repeat (3) @(negedge clk);
        rstn = 1'b1; mOe = 1'b1; mBit = 1'b1;
        repeat (HALF) @(negedge clk);
        nCompared++;
        if (rdCnt - r0 !== 1 || wrCnt - w0 !== 0) begin
            nMismatched++;
            $display("[TB] FAIL midread_strobes: got rd %0d wr %0d expected 1 0", rdCnt - r0, wrCnt - w0);
        end
        readFrame(5'h03, 5'h1F, rd, o1, o2, m2, oe);
        nCompared++;
        if (rd !== 16'h8001 || regAddr !== 5'h1F || oe !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL post_reset_read: got %h reg %h oen %b expected 8001 1f 0", rd, regAddr, oe);
        end
    endtask

    initial begin
        test_reset;
        test_write;
        test_read;
        test_phy_mismatch;
        test_short_preamble;
        test_bad_frames;
        test_reset_mid_read;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
